// File: rtl/continuous_scheduler.sv
// Round-robin scheduler that repeatedly requests measurements for every sensor
// whose continuous-enable bit is set, with a minimum gap and a completion timeout.
module continuous_scheduler #(
    parameter int unsigned PERIOD  = 100000000,
    parameter int unsigned TIMEOUT = 150000000
) (
    input  logic       clk_50m,
    input  logic       reset,
    input  logic       cmd_start,
    input  logic       cmd_stop,
    input  logic [2:0] cmd_addr,
    input  logic       req_ready,
    input  logic       meas_done,
    output logic       req_valid,
    output logic [2:0] req_addr,
    output logic [7:0] active_mask,
    output logic       busy,
    output logic       timeout_err
);

    localparam int unsigned NS = 8;
    localparam int unsigned AW = 3;
    localparam int unsigned PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_PERIOD,
        REQUEST,
        WAIT_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   last_q, last_d;
    logic [PW-1:0]   pcnt_q, pcnt_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic [NS-1:0]   mask_d, start_bit, stop_bit;
    logic            req_valid_d, busy_d, terr_d;
    logic [AW-1:0]   req_addr_d;

    // First set bit strictly after 'last', wrapping; 'last' itself is checked last.
    function automatic logic [AW-1:0] rr_pick(input logic [NS-1:0] mask,
                                              input logic [AW-1:0] last);
        logic [AW-1:0] idx;
        logic [AW-1:0] pick;
        logic          found;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= NS; k++) begin
            idx = last + AW'(k);
            if (!found && mask[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    always_comb begin
        start_bit   = '0;
        stop_bit    = '0;
        state_d     = state_q;
        req_valid_d = req_valid;
        req_addr_d  = req_addr;
        last_d      = last_q;
        pcnt_d      = pcnt_q;
        tcnt_d      = tcnt_q;
        terr_d      = 1'b0;

        if (cmd_start) start_bit[cmd_addr] = 1'b1;
        if (cmd_stop)  stop_bit[cmd_addr]  = 1'b1;
        // Stop is applied after start so a same-cycle pair leaves the bit clear.
        mask_d = (active_mask | start_bit) & ~stop_bit;

        case (state_q)
            IDLE: begin
                if (active_mask != '0) begin
                    state_d     = REQUEST;
                    req_valid_d = 1'b1;
                    req_addr_d  = rr_pick(active_mask, '1);
                end
            end
            WAIT_PERIOD: begin
                if (active_mask == '0) begin
                    state_d = IDLE;
                end else if (pcnt_q == PW'(PERIOD - 1)) begin
                    state_d     = REQUEST;
                    req_valid_d = 1'b1;
                    req_addr_d  = rr_pick(active_mask, last_q);
                end else if (pcnt_q != '1) begin
                    pcnt_d = pcnt_q + PW'(1);
                end
            end
            REQUEST: begin
                // An accepted handshake stands even if the bit is being withdrawn.
                if (req_valid && req_ready) begin
                    state_d     = WAIT_DONE;
                    req_valid_d = 1'b0;
                    tcnt_d      = '0;
                end else if (req_valid) begin
                    if (!active_mask[req_addr]) begin
                        req_valid_d = 1'b0;
                        if (active_mask == '0) state_d = IDLE;
                    end
                end else if (active_mask == '0) begin
                    state_d = IDLE;
                end else begin
                    req_valid_d = 1'b1;
                    req_addr_d  = rr_pick(active_mask, last_q);
                end
            end
            WAIT_DONE: begin
                if (meas_done || (tcnt_q == TW'(TIMEOUT - 1))) begin
                    terr_d  = !meas_done;
                    last_d  = req_addr;
                    pcnt_d  = '0;
                    state_d = WAIT_PERIOD;
                end else if (tcnt_q != '1) begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_50m) begin
        if (reset) begin
            state_q     <= IDLE;
            active_mask <= '0;
            req_valid   <= 1'b0;
            req_addr    <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            last_q      <= '1;
            pcnt_q      <= '0;
            tcnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            active_mask <= mask_d;
            req_valid   <= req_valid_d;
            req_addr    <= req_addr_d;
            busy        <= busy_d;
            timeout_err <= terr_d;
            last_q      <= last_d;
            pcnt_q      <= pcnt_d;
            tcnt_q      <= tcnt_d;
        end
    end

endmodule

// File: tb/tb_continuous_scheduler.sv
// Bench for continuous_scheduler: mask-update table, directed multi-cycle
// scenarios, and a randomized run against a transaction-level reference model.
module tb_continuous_scheduler;

    localparam int P = 10;
    localparam int T = 20;

    logic       clk_50m = 1'b0;
    logic       reset;
    logic       cmd_start, cmd_stop, req_ready, meas_done;
    logic [2:0] cmd_addr;
    logic       req_valid, busy, timeout_err;
    logic [2:0] req_addr;
    logic [7:0] active_mask;

    int total = 0;
    int bad   = 0;

    always #5 clk_50m = ~clk_50m;

    continuous_scheduler #(.PERIOD(P), .TIMEOUT(T)) dut (
        .clk_50m     (clk_50m),
        .reset       (reset),
        .cmd_start   (cmd_start),
        .cmd_stop    (cmd_stop),
        .cmd_addr    (cmd_addr),
        .req_ready   (req_ready),
        .meas_done   (meas_done),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .active_mask (active_mask),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    typedef struct {
        logic       s;
        logic       p;
        logic [2:0] a;
        logic [7:0] m;
    } mvec_t;

    mvec_t tbl [10];

    task automatic cyc();
        @(posedge clk_50m);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        cmd_start = 1'b0;
        cmd_stop  = 1'b0;
        cmd_addr  = 3'd0;
        req_ready = 1'b0;
        meas_done = 1'b0;
        cyc();
        reset = 1'b0;
    endtask

    task automatic cmd(input logic s, input logic p, input logic [2:0] a);
        cmd_start = s;
        cmd_stop  = p;
        cmd_addr  = a;
        cyc();
        cmd_start = 1'b0;
        cmd_stop  = 1'b0;
    endtask

    task automatic wait_valid(input int maxc, output int k);
        k = 0;
        while (!req_valid && k < maxc) begin
            cyc();
            k++;
        end
    endtask

    // Round-robin rule: first enabled sensor after 'last', wrapping, last itself as fallback.
    function automatic int next_after(input logic [7:0] m, input int last);
        for (int j = 1; j <= 8; j++) begin
            if (m[(last + j) % 8]) return (last + j) % 8;
        end
        return last;
    endfunction

    task automatic random_phase(input int n);
        logic [7:0] mm, pre_mask, sb, pb;
        logic [2:0] pre_addr;
        logic       pre_valid, hs, md, exp_terr;
        bit         idle_seen, in_flight, win, win_nz;
        int         last, since_hs, d_plan, hs_addr, win_k;
        do_reset();
        mm = '0; last = 7; idle_seen = 1'b1; in_flight = 1'b0; win = 1'b0; win_nz = 1'b0;
        since_hs = 0; d_plan = 0; hs_addr = 0; win_k = 0;
        for (int c = 0; c < n; c++) begin
            cmd_start = ($urandom_range(0, 7) == 0);
            cmd_stop  = ($urandom_range(0, 11) == 0);
            cmd_addr  = 3'($urandom_range(0, 7));
            req_ready = ($urandom_range(0, 2) != 0);
            if (in_flight) md = (d_plan <= T) && (since_hs + 1 == d_plan);
            else           md = ($urandom_range(0, 15) == 0);
            meas_done = md;
            pre_mask  = mm;
            pre_valid = req_valid;
            pre_addr  = req_addr;
            hs        = req_valid && req_ready;
            sb = '0;
            pb = '0;
            if (cmd_start) sb[cmd_addr] = 1'b1;
            if (cmd_stop)  pb[cmd_addr] = 1'b1;
            if (!in_flight && !hs && pre_mask == 8'h00) idle_seen = 1'b1;
            if (win) win_nz = win_nz && (pre_mask != 8'h00);
            cyc();
            mm = (mm | sb) & ~pb;
            chk("rnd_mask", 32'(active_mask), 32'(mm));
            if (win) begin
                win_k++;
                if (win_nz) chk("rnd_period", 32'(req_valid), 32'(win_k == P));
                if (!win_nz || win_k == P) win = 1'b0;
            end
            exp_terr = 1'b0;
            if (in_flight) begin
                since_hs++;
                exp_terr = (d_plan > T) && (since_hs == T);
                if (md || exp_terr) begin
                    last = hs_addr; in_flight = 1'b0;
                    win = 1'b1; win_k = 0; win_nz = 1'b1;
                end
            end
            chk("rnd_terr", 32'(timeout_err), 32'(exp_terr));
            if (hs) begin
                in_flight = 1'b1; since_hs = 0; hs_addr = int'(pre_addr);
                d_plan = $urandom_range(1, T + 4);
                chk("rnd_hs_drop", 32'(req_valid), 0);
            end
            if (req_valid && !pre_valid) begin
                chk("rnd_pick", 32'(req_addr), next_after(pre_mask, idle_seen ? 7 : last));
                idle_seen = 1'b0;
            end
            if (req_valid && pre_valid) chk("rnd_hold", 32'(req_addr), 32'(pre_addr));
        end
        cmd_start = 1'b0; cmd_stop = 1'b0; req_ready = 1'b0; meas_done = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int k, first, pulses, vk;
        bit stable;
        logic [2:0] exp_seq [5];

        tbl[0] = '{1'b1, 1'b0, 3'd0, 8'h01};
        tbl[1] = '{1'b1, 1'b0, 3'd7, 8'h81};
        tbl[2] = '{1'b1, 1'b0, 3'd7, 8'h81};
        tbl[3] = '{1'b0, 1'b1, 3'd3, 8'h81};
        tbl[4] = '{1'b1, 1'b1, 3'd2, 8'h81};
        tbl[5] = '{1'b0, 1'b1, 3'd0, 8'h80};
        tbl[6] = '{1'b1, 1'b0, 3'd4, 8'h90};
        tbl[7] = '{1'b1, 1'b1, 3'd7, 8'h10};
        tbl[8] = '{1'b0, 1'b1, 3'd4, 8'h00};
        tbl[9] = '{1'b1, 1'b0, 3'd1, 8'h02};
        exp_seq[0] = 3'd0; exp_seq[1] = 3'd2; exp_seq[2] = 3'd5;
        exp_seq[3] = 3'd0; exp_seq[4] = 3'd2;

        do_reset();
        chk("rst_valid", 32'(req_valid), 0);
        chk("rst_addr",  32'(req_addr), 0);
        chk("rst_mask",  32'(active_mask), 0);
        chk("rst_busy",  32'(busy), 0);
        chk("rst_terr",  32'(timeout_err), 0);

        // Mask set/clear rules
        for (int i = 0; i < 10; i++) begin
            cmd(tbl[i].s, tbl[i].p, tbl[i].a);
            chk($sformatf("tbl_mask_%0d", i), 32'(active_mask), 32'(tbl[i].m));
        end

        // Single sensor: request one cycle after the mask, then exact period gap
        do_reset();
        req_ready = 1'b1;
        cmd(1'b1, 1'b0, 3'd3);
        chk("s_mask", 32'(active_mask), 32'h08);
        chk("s_valid_early", 32'(req_valid), 0);
        cyc();
        chk("s_valid", 32'(req_valid), 1);
        chk("s_addr", 32'(req_addr), 3);
        chk("s_busy", 32'(busy), 1);
        cyc();
        chk("s_hs_drop", 32'(req_valid), 0);
        meas_done = 1'b1;
        cyc();
        meas_done = 1'b0;
        wait_valid(20, k);
        chk("s_period_gap", 32'(k), P);
        chk("s_addr2", 32'(req_addr), 3);

        // Round robin over mask 0x25
        do_reset();
        cmd(1'b1, 1'b0, 3'd0);
        cmd(1'b1, 1'b0, 3'd2);
        cmd(1'b1, 1'b0, 3'd5);
        chk("rr_mask", 32'(active_mask), 32'h25);
        for (int i = 0; i < 5; i++) begin
            wait_valid(30, k);
            chk($sformatf("rr_valid_%0d", i), 32'(req_valid), 1);
            chk($sformatf("rr_addr_%0d", i), 32'(req_addr), 32'(exp_seq[i]));
            req_ready = 1'b1;
            cyc();
            req_ready = 1'b0;
            meas_done = 1'b1;
            cyc();
            meas_done = 1'b0;
        end

        // Held request without ready, then withdrawn
        do_reset();
        cmd(1'b1, 1'b0, 3'd6);
        wait_valid(5, k);
        chk("hold_valid", 32'(req_valid), 1);
        stable = 1'b1;
        repeat (30) begin
            cyc();
            if (!(req_valid && req_addr == 3'd6)) stable = 1'b0;
        end
        chk("hold_stable", 32'(stable), 1);
        cmd(1'b0, 1'b1, 3'd6);
        chk("stop_mask", 32'(active_mask), 0);
        cyc();
        chk("stop_valid", 32'(req_valid), 0);
        chk("stop_busy", 32'(busy), 0);

        // Withdrawn selection with another sensor still enabled
        do_reset();
        cmd(1'b1, 1'b0, 3'd1);
        cmd(1'b1, 1'b0, 3'd4);
        chk("rs_addr1", 32'(req_addr), 1);
        cmd(1'b0, 1'b1, 3'd1);
        chk("rs_valid_hold", 32'(req_valid), 1);
        cyc();
        chk("rs_drop", 32'(req_valid), 0);
        chk("rs_busy", 32'(busy), 1);
        cyc();
        chk("rs_valid", 32'(req_valid), 1);
        chk("rs_addr4", 32'(req_addr), 4);

        // Completion timeout
        do_reset();
        req_ready = 1'b1;
        cmd(1'b1, 1'b0, 3'd2);
        cyc();
        chk("to_valid", 32'(req_valid), 1);
        cyc();
        req_ready = 1'b0;
        first = 0; pulses = 0; vk = 0;
        for (int i = 1; i <= 35; i++) begin
            cyc();
            if (timeout_err) begin
                pulses++;
                if (first == 0) first = i;
            end
            if (req_valid && vk == 0) vk = i;
        end
        chk("to_first", 32'(first), T);
        chk("to_pulses", 32'(pulses), 1);
        chk("to_rearm", 32'(vk), T + P);
        chk("to_addr", 32'(req_addr), 2);

        // Same-cycle start/stop and reset during WAIT_DONE
        do_reset();
        cmd(1'b1, 1'b1, 3'd5);
        chk("ss_mask", 32'(active_mask), 0);
        cyc();
        chk("ss_busy", 32'(busy), 0);
        chk("ss_valid", 32'(req_valid), 0);
        req_ready = 1'b1;
        cmd(1'b1, 1'b0, 3'd1);
        cyc();
        cyc();
        req_ready = 1'b0;
        repeat (3) cyc();
        chk("wd_busy", 32'(busy), 1);
        chk("wd_valid", 32'(req_valid), 0);
        reset = 1'b1; cmd_start = 1'b1; cmd_addr = 3'd4;
        cyc();
        reset = 1'b0; cmd_start = 1'b0;
        chk("wr_valid", 32'(req_valid), 0);
        chk("wr_addr", 32'(req_addr), 0);
        chk("wr_mask", 32'(active_mask), 0);
        chk("wr_busy", 32'(busy), 0);
        chk("wr_terr", 32'(timeout_err), 0);
        cyc();
        chk("wr_cmd_ignored", 32'(active_mask), 0);
        chk("wr_idle", 32'(busy), 0);

        random_phase(3000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/continuous_scheduler.md
CONTINUOUS_SCHEDULER -- requirements
Module: continuous_scheduler

Interface
REQ-001 Parameter PERIOD, default 100000000, gives the minimum cycles from end of one measurement to the next request (2 s at 50 MHz).
REQ-002 Parameter TIMEOUT, default 150000000, gives the maximum cycles allowed in WAIT_DONE before abort.
REQ-003 Port clk_50m  input  1  is the single clock; all logic SHALL be clocked on its rising edge.
REQ-004 Port reset  input  1  is a synchronous, active-high reset.
REQ-005 Port cmd_start  input  1  is a one-cycle pulse that enables continuous sensing for sensor cmd_addr.
REQ-006 Port cmd_stop  input  1  is a one-cycle pulse that disables continuous sensing for sensor cmd_addr.
REQ-007 Port cmd_addr  input  3  is the sensor address qualifying cmd_start and cmd_stop.
REQ-008 Port req_ready  input  1  is high when the main controller can accept a measurement request (its idle flag).
REQ-009 Port meas_done  input  1  is a one-cycle pulse marking completion of the accepted measurement (UART TX done).
REQ-010 Port req_valid  output  1  indicates a pending measurement request.
REQ-011 Port req_addr  output  3  is the sensor address of the pending request.
REQ-012 Port active_mask  output  8  gives the per-sensor continuous-enable bits.
REQ-013 Port busy  output  1  is high in every state except IDLE.
REQ-014 Port timeout_err  output  1  is a one-cycle pulse on WAIT_DONE abort.

Function
REQ-015 Mask update: cmd_start sets, and cmd_stop clears, active_mask[cmd_addr], visible next cycle; both in one cycle -> clear wins; start on a set bit or stop on a clear bit -> no change.
REQ-016 The FSM SHALL have states IDLE, WAIT_PERIOD, REQUEST and WAIT_DONE, all registered.
REQ-017 IDLE: when the updated mask is nonzero, the FSM SHALL go to REQUEST next cycle with no period wait, selecting the lowest set address.
REQ-018 REQUEST: req_valid=1 and req_addr is stable; a handshake occurs when req_valid && req_ready, and the FSM then goes to WAIT_DONE and drops req_valid next cycle.
REQ-019 REQUEST: if the selected bit is cleared before the handshake, req_valid SHALL drop next cycle and the FSM SHALL reselect (stay in REQUEST), or go to IDLE if the mask is empty.
REQ-020 WAIT_DONE: on meas_done, the last-served pointer <= req_addr, the period counter clears, and the FSM goes to WAIT_PERIOD; the mask is nonzero check is made at PERIOD expiry.
REQ-021 WAIT_DONE: a stop for the in-flight address SHALL NOT abort the wait; the measurement completes normally.
REQ-022 WAIT_DONE timeout: when the timeout counter reaches TIMEOUT-1 without meas_done, timeout_err pulses for 1 cycle and the FSM follows the REQ-020 path.
REQ-023 WAIT_PERIOD lasts exactly PERIOD cycles, then goes to REQUEST (mask nonzero) or IDLE (mask zero); a mask that becomes empty mid-count SHALL send the FSM to IDLE next cycle.
REQ-024 Round-robin selection: the first set bit strictly after the last-served pointer, wrapping 7->0; if only the last-served bit is set, it is reselected.
REQ-025 Selection is computed when entering REQUEST or reselecting, and SHALL be held while req_valid=1.
REQ-026 meas_done and req_ready outside their states SHALL be ignored.
REQ-027 Counters SHALL be sized $clog2 of their parameter and saturate, never wrapping.

Reset
REQ-028 On reset (sync, active-high), the FSM SHALL be in IDLE with active_mask=0, req_valid=0, req_addr=0, busy=0, timeout_err=0, last-served pointer=7, and all counters=0, regardless of state mid-operation.
REQ-029 Commands in the reset cycle SHALL be ignored.

Verification (PERIOD=10, TIMEOUT=20)
REQ-030 cmd_start addr 3 from IDLE, req_ready=1 -> req_valid=1, req_addr=3 one cycle after mask set; meas_done -> next req_valid exactly 10 cycles later, addr 3.
REQ-031 Mask 0x25, repeated completions -> req_addr sequence 0, 2, 5, 0, 2.
REQ-032 req_ready held 0 for 30 cycles in REQUEST -> req_valid and req_addr stable; cmd_stop on that addr -> req_valid=0 next cycle, FSM to IDLE, busy=0.
REQ-033 No meas_done in WAIT_DONE -> timeout_err single pulse 20 cycles after handshake, then WAIT_PERIOD.
REQ-034 cmd_start and cmd_stop same cycle, same addr -> bit stays 0; reset asserted in WAIT_DONE -> all outputs at reset values next cycle.
